// File: rtl/hdmi_text_controller.sv
// hdmi_text_controller: AXI4-Lite register file of 9 rectangles plus a control word,
// 640x480@60 VGA timing from a divide-by-4 of the bus clock, and a rectangle compositor.
// Ports: axi_* AXI4-Lite slave (single clock axi_aclk, sync active-high axi_areset);
//        vga_red/green/blue 4-bit colour, vga_hsync/vsync (active low), vga_vde, vga_pclk.
// Option: define AXI_READBACK_EN to return register contents on reads (otherwise rdata = 0).
module hdmi_text_controller #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int NUM_RECTS        = 9
) (
    input  logic                        axi_aclk,
    input  logic                        axi_areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [2:0]                  axi_awprot,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0] axi_wdata,
    input  logic [3:0]                  axi_wstrb,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic [1:0]                  axi_bresp,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr,
    input  logic [2:0]                  axi_arprot,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rvalid,
    input  logic                        axi_rready,
    output logic [3:0]                  vga_red,
    output logic [3:0]                  vga_green,
    output logic [3:0]                  vga_blue,
    output logic                        vga_hsync,
    output logic                        vga_vsync,
    output logic                        vga_vde,
    output logic                        vga_pclk
);

    localparam int         NREGS    = 4 * NUM_RECTS + 1;
    localparam logic [5:0] CTRL_IDX = 6'(4 * NUM_RECTS);

    logic [31:0] r_regs [NREGS];
    logic        r_wr_rdy;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_div;

    logic        clk_25MHz;
    logic        hsync;
    logic        vsync;
    logic        vde;
    logic [9:0]  drawX;
    logic [9:0]  drawY;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    logic [5:0]  w_widx;
    logic [5:0]  w_ridx;
    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [31:0] w_rd_val;
    logic        w_unused;

    assign w_widx    = axi_awaddr[7:2];
    assign w_ridx    = axi_araddr[7:2];
    assign w_wr_fire = r_wr_rdy && axi_awvalid && axi_wvalid;
    assign w_rd_fire = r_arready && axi_arvalid;

`ifdef AXI_READBACK_EN
    assign w_rd_val = (w_ridx <= CTRL_IDX) ? r_regs[w_ridx] : 32'd0;
    assign w_unused = ^{axi_awprot, axi_arprot,
                        axi_awaddr[C_AXI_ADDR_WIDTH-1:8], axi_awaddr[1:0],
                        axi_araddr[C_AXI_ADDR_WIDTH-1:8], axi_araddr[1:0]};
`else
    assign w_rd_val = 32'd0;
    assign w_unused = ^{axi_awprot, axi_arprot,
                        axi_awaddr[C_AXI_ADDR_WIDTH-1:8], axi_awaddr[1:0],
                        axi_araddr, w_ridx};
`endif

    // AXI slave: ready is registered, so the !ready term keeps it a one-cycle pulse
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_wr_rdy  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_wr_rdy <= axi_awvalid && axi_wvalid && !r_bvalid && !r_wr_rdy;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                if (w_widx <= CTRL_IDX)
                    for (int b = 0; b < 4; b++)
                        if (axi_wstrb[b])
                            r_regs[w_widx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end else if (r_bvalid && axi_bready) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= axi_arvalid && !r_rvalid && !r_arready;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_val;
            end else if (r_rvalid && axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Pixel position steps once per four bus clocks, on the divider wrap
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_div <= 2'd0;
            drawX <= 10'd0;
            drawY <= 10'd0;
        end else begin
            r_div <= r_div + 2'd1;
            if (r_div == 2'd3) begin
                if (drawX == 10'd799) begin
                    drawX <= 10'd0;
                    drawY <= (drawY == 10'd524) ? 10'd0 : drawY + 10'd1;
                end else begin
                    drawX <= drawX + 10'd1;
                end
            end
        end
    end

    assign clk_25MHz = r_div[1];
    assign hsync     = !((drawX >= 10'd656) && (drawX <= 10'd751));
    assign vsync     = !((drawY >= 10'd490) && (drawY <= 10'd491));
    assign vde       = (drawX < 10'd640) && (drawY < 10'd480);

    // Walk from the highest index down so the lowest matching rectangle wins
    always_comb begin
        red   = 4'd0;
        green = 4'd0;
        blue  = 4'd0;
        if (vde && r_regs[CTRL_IDX][16]) begin
            {red, green, blue} = r_regs[CTRL_IDX][11:0];
            for (int k = NUM_RECTS - 1; k >= 0; k--) begin
                if (r_regs[4*k+2][24] &&
                    drawX >= r_regs[4*k][9:0]   && drawX < r_regs[4*k+1][9:0] &&
                    drawY >= r_regs[4*k][25:16] && drawY < r_regs[4*k+1][25:16]) begin
                    red   = r_regs[4*k+2][23:20];
                    green = r_regs[4*k+2][15:12];
                    blue  = r_regs[4*k+2][7:4];
                end
            end
        end
    end

    assign axi_awready = r_wr_rdy;
    assign axi_wready  = r_wr_rdy;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = 2'b00;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = 2'b00;

    assign vga_red   = red;
    assign vga_green = green;
    assign vga_blue  = blue;
    assign vga_hsync = hsync;
    assign vga_vsync = vsync;
    assign vga_vde   = vde;
    assign vga_pclk  = clk_25MHz;

endmodule

// File: tb/tb_hdmi_text_controller.sv
// tb_hdmi_text_controller: directed bench for hdmi_text_controller.
// Covers reset, pixel clock, sync timing, AXI writes/reads and rectangle compositing.
module tb_hdmi_text_controller;

`ifdef AXI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        axi_aclk = 1'b0;
    logic        axi_areset = 1'b1;
    logic [15:0] axi_awaddr = '0;
    logic [2:0]  axi_awprot = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [15:0] axi_araddr = '0;
    logic [2:0]  axi_arprot = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic        vga_hsync, vga_vsync, vga_vde, vga_pclk;

    int nvec = 0;
    int nmis = 0;

    always #5 axi_aclk = ~axi_aclk;

    hdmi_text_controller dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_vde(vga_vde), .vga_pclk(vga_pclk)
    );

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int hold,
                             output bit ok, output logic [1:0] resp,
                             output logic held, output logic after);
        ok = 1'b0; held = 1'b0; after = 1'b1; resp = 2'b11;
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s; axi_bready = 1'b0;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge axi_aclk);
            if (axi_awready && axi_wready) begin ok = 1'b1; break; end
        end
        @(negedge axi_aclk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        if (!ok) return;
        ok = axi_bvalid;
        resp = axi_bresp;
        repeat (hold) @(negedge axi_aclk);
        held = axi_bvalid;
        axi_bready = 1'b1;
        @(negedge axi_aclk);
        axi_bready = 1'b0;
        after = axi_bvalid;
    endtask

    task automatic axi_read(input logic [15:0] a, output bit ok,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic after);
        ok = 1'b0; data = 'x; resp = 2'b11; after = 1'b1;
        axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge axi_aclk);
            if (axi_arready) begin ok = 1'b1; break; end
        end
        @(negedge axi_aclk);
        axi_arvalid = 1'b0;
        if (!ok) return;
        ok = axi_rvalid;
        data = axi_rdata;
        resp = axi_rresp;
        axi_rready = 1'b1;
        @(negedge axi_aclk);
        axi_rready = 1'b0;
        after = axi_rvalid;
    endtask

    task automatic wait_pixel(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            if (dut.drawX == 10'(x) && dut.drawY == 10'(y)) begin ok = 1'b1; break; end
            @(negedge axi_aclk);
        end
    endtask

    task automatic test_reset;
        axi_areset = 1'b1;
        repeat (4) @(negedge axi_aclk);
        nvec++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid} !== 5'b0) begin
            nmis++; $display("FAIL reset_hs got %b want 00000",
                {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid});
        end
        nvec++;
        if ({axi_rdata, axi_bresp, axi_rresp} !== 36'd0) begin
            nmis++; $display("FAIL reset_data rdata=%h bresp=%b rresp=%b want 0",
                axi_rdata, axi_bresp, axi_rresp);
        end
        nvec++;
        if ({dut.clk_25MHz, dut.drawX, dut.drawY} !== 21'd0) begin
            nmis++; $display("FAIL reset_cnt clk=%b x=%0d y=%0d want 0 0 0",
                dut.clk_25MHz, dut.drawX, dut.drawY);
        end
        nvec++;
        if ({vga_hsync, vga_vsync} !== 2'b11) begin
            nmis++; $display("FAIL reset_sync got %b want 11", {vga_hsync, vga_vsync});
        end
        nvec++;
        if ({vga_red, vga_green, vga_blue} !== 12'h000) begin
            nmis++; $display("FAIL reset_rgb got %h want 000", {vga_red, vga_green, vga_blue});
        end
        axi_areset = 1'b0;
    endtask

    task automatic test_pclk;
        logic [7:0] pat;
        pat = 8'b0110_0110;
        for (int i = 0; i < 8; i++) begin
            @(negedge axi_aclk);
            nvec++;
            if (vga_pclk !== pat[7-i]) begin
                nmis++; $display("FAIL pclk[%0d] got %b want %b", i, vga_pclk, pat[7-i]);
            end
        end
        nvec++;
        if (dut.drawX !== 10'd2) begin
            nmis++; $display("FAIL pclk_drawx got %0d want 2", dut.drawX);
        end
    endtask

    task automatic test_sync;
        int   hx [6] = '{639, 640, 655, 656, 751, 752};
        logic hs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic ve [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bit ok;
        for (int i = 0; i < 6; i++) begin
            wait_pixel(hx[i], 0, ok);
            nvec++;
            if (!ok) begin
                nmis++; $display("FAIL sync_wait x=%0d got timeout want reached", hx[i]);
            end else if ({vga_hsync, vga_vde, vga_vsync} !== {hs[i], ve[i], 1'b1}) begin
                nmis++; $display("FAIL sync x=%0d hs/vde/vs got %b want %b", hx[i],
                    {vga_hsync, vga_vde, vga_vsync}, {hs[i], ve[i], 1'b1});
            end
        end
    endtask

    task automatic test_write_read;
        bit ok; logic [1:0] resp; logic held, after; logic [31:0] d;
        axi_write(16'h0008, 32'h1234_5678, 4'hF, 3, ok, resp, held, after);
        nvec++;
        if ({ok, resp, held, after} !== 5'b1_00_1_0) begin
            nmis++; $display("FAIL wr_basic ok/resp/held/after got %b want 100 1 0",
                {ok, resp, held, after});
        end
        axi_read(16'h0008, ok, d, resp, after);
        nvec++;
        if ({ok, d, resp, after} !== {1'b1, (RB ? 32'h1234_5678 : 32'h0), 2'b00, 1'b0}) begin
            nmis++; $display("FAIL rd_basic ok=%b data=%h resp=%b after=%b want data %h",
                ok, d, resp, after, (RB ? 32'h1234_5678 : 32'h0));
        end
    endtask

    task automatic test_strobe;
        bit ok; logic [1:0] resp; logic held, after; logic [31:0] d;
        axi_write(16'h0004, 32'hFFFF_FFFF, 4'h3, 0, ok, resp, held, after);
        axi_read(16'h0004, ok, d, resp, after);
        nvec++;
        if ({ok, d} !== {1'b1, (RB ? 32'h0000_FFFF : 32'h0)}) begin
            nmis++; $display("FAIL strobe ok=%b data=%h want %h",
                ok, d, (RB ? 32'h0000_FFFF : 32'h0));
        end
    endtask

    task automatic test_out_of_range;
        bit ok; logic [1:0] resp; logic held, after; logic [31:0] d;
        axi_write(16'h00FC, 32'hDEAD_BEEF, 4'hF, 0, ok, resp, held, after);
        nvec++;
        if ({ok, resp} !== 3'b1_00) begin
            nmis++; $display("FAIL oor_wr ok=%b resp=%b want 1 00", ok, resp);
        end
        axi_read(16'h00FC, ok, d, resp, after);
        nvec++;
        if ({ok, d, resp} !== {1'b1, 32'h0, 2'b00}) begin
            nmis++; $display("FAIL oor_rd ok=%b data=%h resp=%b want 1 0 00", ok, d, resp);
        end
    endtask

    task automatic test_lone_valid;
        logic seen;
        seen = 1'b0;
        axi_awaddr = 16'h000C; axi_awvalid = 1'b1;
        repeat (4) begin @(negedge axi_aclk); seen = seen | axi_awready | axi_wready; end
        axi_awvalid = 1'b0; axi_wvalid = 1'b1;
        repeat (4) begin @(negedge axi_aclk); seen = seen | axi_awready | axi_wready; end
        axi_wvalid = 1'b0;
        @(negedge axi_aclk);
        nvec++;
        if ({seen, axi_bvalid} !== 2'b00) begin
            nmis++; $display("FAIL lone_valid ready/bvalid got %b want 00", {seen, axi_bvalid});
        end
    endtask

    task automatic test_rects;
        int         px [8] = '{4, 20, 12, 16, 20, 32, 100, 640};
        int         py [8] = '{4, 7, 8, 8, 8, 8, 8, 8};
        logic [11:0] pe [8] = '{12'hF00, 12'hF00, 12'hF00, 12'h0F0,
                                12'h0F0, 12'hF00, 12'hF00, 12'h000};
        logic [15:0] wa [8] = '{16'h0000, 16'h0004, 16'h0008, 16'h0010,
                                16'h0014, 16'h0018, 16'h0090, 16'h0090};
        logic [31:0] wd [8] = '{32'h0000_0000, 32'h0010_0010, 32'h01FF_0000, 32'h0008_0008,
                                32'h0020_0020, 32'h0100_FF00, 32'hFFFE_0F00, 32'hFF01_FFFF};
        logic [3:0]  ws [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h3, 4'h4};
        bit ok; logic [1:0] resp; logic held, after;
        for (int i = 0; i < 8; i++) begin
            axi_write(wa[i], wd[i], ws[i], 0, ok, resp, held, after);
            if (!ok) begin
                nvec++; nmis++;
                $display("FAIL prog_wr[%0d] got no response want response", i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            wait_pixel(px[i], py[i], ok);
            nvec++;
            if (!ok) begin
                nmis++; $display("FAIL pix_wait (%0d,%0d) got timeout", px[i], py[i]);
            end else if ({vga_red, vga_green, vga_blue} !== pe[i]) begin
                nmis++; $display("FAIL pix (%0d,%0d) got %h want %h", px[i], py[i],
                    {vga_red, vga_green, vga_blue}, pe[i]);
            end
        end
    endtask

    task automatic test_disable;
        int px [3] = '{4, 20, 100};
        bit ok; logic [1:0] resp; logic held, after;
        axi_write(16'h0090, 32'h0000_0F00, 4'hF, 0, ok, resp, held, after);
        for (int i = 0; i < 3; i++) begin
            wait_pixel(px[i], 10, ok);
            nvec++;
            if (!ok) begin
                nmis++; $display("FAIL dis_wait (%0d,10) got timeout", px[i]);
            end else if ({vga_vde, vga_red, vga_green, vga_blue} !== 13'h1000) begin
                nmis++; $display("FAIL dis (%0d,10) vde/rgb got %b/%h want 1/000", px[i],
                    vga_vde, {vga_red, vga_green, vga_blue});
            end
        end
    endtask

    initial begin
        test_reset;
        test_pclk;
        test_sync;
        test_write_read;
        test_strobe;
        test_out_of_range;
        test_lone_valid;
        test_rects;
        test_disable;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
